// File: rtl/evt_frame_scheduler.sv
// Double-buffered event frame scheduler: clears the write bank, accumulates for FRAME_TICKS
// cycles, then swaps banks once the video reader is idle. Optional macro: EVT_FRAME_DROP_CNT_EN.
module evt_frame_scheduler #(
  parameter int FRAME_TICKS = 1000000,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 rd_busy_i,
  input  logic                 clr_done_i,
  output logic                 clr_req_o,
  output logic                 clr_bank_o,
  output logic                 wr_en_o,
  output logic                 wr_bank_o,
  output logic                 rd_bank_o,
  output logic                 frame_valid_o,
  output logic                 swap_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o
`ifdef EVT_FRAME_DROP_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] drop_cnt_o
`endif
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_ACCUM   = 3'd2;
  localparam logic [2:0] ST_WAIT_RD = 3'd3;
  localparam logic [2:0] ST_SWAP    = 3'd4;

  // Tick counter must reach 2*FRAME_TICKS-1 for the discard timeout.
  localparam int              TICK_W     = $clog2(2 * FRAME_TICKS);
  localparam logic [TICK_W-1:0] LAST_ACCUM = TICK_W'(FRAME_TICKS - 1);
  localparam logic [TICK_W-1:0] LAST_WAIT  = TICK_W'(2 * FRAME_TICKS - 1);

  logic [2:0]           state_reg, state_next;
  logic [TICK_W-1:0]    tick_reg, tick_next;
  logic                 clr_req_reg, wr_en_reg, swap_reg, frame_valid_reg;
  logic                 wr_bank_reg, rd_bank_reg;
  logic [CNT_WIDTH-1:0] frame_cnt_reg;
  logic                 swap_commit;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (enable_i) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        // A stop request only takes effect once the clear engine has finished.
        if (clr_done_i) state_next = enable_i ? ST_ACCUM : ST_IDLE;
      end
      ST_ACCUM: begin
        if (!enable_i)                  state_next = ST_IDLE;
        else if (tick_reg == LAST_ACCUM) state_next = rd_busy_i ? ST_WAIT_RD : ST_SWAP;
      end
      ST_WAIT_RD: begin
        if (!enable_i)                  state_next = ST_IDLE;
        else if (!rd_busy_i)            state_next = ST_SWAP;
        else if (tick_reg == LAST_WAIT) state_next = ST_CLEAR;
      end
      ST_SWAP: begin
        state_next = enable_i ? ST_CLEAR : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tick_next = tick_reg;
    if (state_next == ST_ACCUM && state_reg != ST_ACCUM)
      tick_next = '0;
    else if (state_next == ST_ACCUM || state_next == ST_WAIT_RD)
      tick_next = tick_reg + 1'b1;
  end

  assign swap_commit = (state_reg == ST_SWAP) && (state_next == ST_CLEAR);

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= ST_IDLE;
      tick_reg        <= '0;
      clr_req_reg     <= 1'b0;
      wr_en_reg       <= 1'b0;
      swap_reg        <= 1'b0;
      frame_valid_reg <= 1'b0;
      wr_bank_reg     <= 1'b0;
      rd_bank_reg     <= 1'b1;
      frame_cnt_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      clr_req_reg <= (state_next == ST_CLEAR);
      wr_en_reg   <= (state_next == ST_ACCUM) || (state_next == ST_WAIT_RD);
      swap_reg    <= (state_next == ST_SWAP);
      if (swap_commit) begin
        wr_bank_reg     <= ~wr_bank_reg;
        rd_bank_reg     <= ~rd_bank_reg;
        frame_valid_reg <= 1'b1;
        frame_cnt_reg   <= frame_cnt_reg + 1'b1;
      end else if (state_next == ST_IDLE) begin
        frame_valid_reg <= 1'b0;
      end
    end
  end

`ifdef EVT_FRAME_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] drop_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      drop_cnt_reg <= '0;
    else if (state_reg == ST_WAIT_RD && state_next == ST_CLEAR)
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
  end

  assign drop_cnt_o = drop_cnt_reg;
`endif

  assign clr_req_o     = clr_req_reg;
  assign clr_bank_o    = wr_bank_reg;
  assign wr_en_o       = wr_en_reg;
  assign wr_bank_o     = wr_bank_reg;
  assign rd_bank_o     = rd_bank_reg;
  assign frame_valid_o = frame_valid_reg;
  assign swap_o        = swap_reg;
  assign frame_cnt_o   = frame_cnt_reg;

endmodule

// File: tb/tb_evt_frame_scheduler.sv
// Directed bench for evt_frame_scheduler: main instance with FRAME_TICKS=8, plus a small
// FRAME_TICKS=2 / CNT_WIDTH=4 instance used to exercise frame counter wrap in few cycles.
module tb_evt_frame_scheduler;

  localparam int FT  = 8;
  localparam int CW  = 16;
  localparam int FTW = 2;
  localparam int CWW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, enable, rd_busy, clr_done;
  logic          clr_req, clr_bank, wr_en, wr_bank, rd_bank, frame_valid, swap;
  logic [CW-1:0] frame_cnt;

  logic           enable_w, rd_busy_w, clr_done_w;
  logic           clr_req_w, clr_bank_w, wr_en_w, wr_bank_w, rd_bank_w, frame_valid_w, swap_w;
  logic [CWW-1:0] frame_cnt_w;

`ifdef EVT_FRAME_DROP_CNT_EN
  logic [CW-1:0]  drop_cnt;
  logic [CWW-1:0] drop_cnt_w;
`endif

  int tests   = 0;
  int fails   = 0;
  int inv_err = 0;

  evt_frame_scheduler #(.FRAME_TICKS(FT), .CNT_WIDTH(CW)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .rd_busy_i(rd_busy),
    .clr_done_i(clr_done), .clr_req_o(clr_req), .clr_bank_o(clr_bank), .wr_en_o(wr_en),
    .wr_bank_o(wr_bank), .rd_bank_o(rd_bank), .frame_valid_o(frame_valid), .swap_o(swap),
    .frame_cnt_o(frame_cnt)
`ifdef EVT_FRAME_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt)
`endif
  );

  evt_frame_scheduler #(.FRAME_TICKS(FTW), .CNT_WIDTH(CWW)) u_dut_w (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable_w), .rd_busy_i(rd_busy_w),
    .clr_done_i(clr_done_w), .clr_req_o(clr_req_w), .clr_bank_o(clr_bank_w),
    .wr_en_o(wr_en_w), .wr_bank_o(wr_bank_w), .rd_bank_o(rd_bank_w),
    .frame_valid_o(frame_valid_w), .swap_o(swap_w), .frame_cnt_o(frame_cnt_w)
`ifdef EVT_FRAME_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt_w)
`endif
  );

  // Bank relationship invariants, sampled every cycle on both instances.
  always @(negedge clk) begin
    if (rd_bank !== ~wr_bank)     inv_err++;
    if (clr_bank !== wr_bank)     inv_err++;
    if (rd_bank_w !== ~wr_bank_w) inv_err++;
    if (clr_bank_w !== wr_bank_w) inv_err++;
  end

  task automatic apply_reset;
    rst_n    = 1'b0;
    enable   = 1'b0;
    rd_busy  = 1'b0;
    clr_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Clear engine model: answer clr_req with a one-cycle clr_done pulse after 'delay' cycles.
  task automatic do_clear(input int delay, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (clr_req === 1'b1) begin ok = 1'b1; break; end
    end
    if (ok) begin
      repeat (delay) @(posedge clk);
      #1 clr_done = 1'b1;
      @(posedge clk);
      #1 clr_done = 1'b0;
    end
  endtask

  task automatic wait_swap(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (swap === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; rd_busy = 1'b0; clr_done = 1'b0;
    enable_w = 1'b0; rd_busy_w = 1'b0; clr_done_w = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({clr_req, clr_bank, wr_en, wr_bank, rd_bank, frame_valid, swap} !== 7'b0000100) begin
      fails++;
      $display("FAIL reset_flags: got %b expected %b",
               {clr_req, clr_bank, wr_en, wr_bank, rd_bank, frame_valid, swap}, 7'b0000100);
    end
    tests++;
    if (frame_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
    end
`ifdef EVT_FRAME_DROP_CNT_EN
    tests++;
    if (drop_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
    end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (clr_req !== 1'b0 || wr_en !== 1'b0) begin
      fails++; $display("FAIL idle_no_enable: clr_req=%b wr_en=%b expected 0 0", clr_req, wr_en);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic_frame;
    bit ok;
    int cnt;
    apply_reset();
    enable = 1'b1;
    do_clear(2, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_clr_req: got timeout expected clr_req"); end
    cnt = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (swap === 1'b1) begin ok = 1'b1; break; end
      if (wr_en === 1'b1) cnt++;
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_swap_seen: got timeout expected swap_o"); end
    tests++;
    if (cnt != FT) begin fails++; $display("FAIL basic_wr_en_cycles: got %0d expected %0d", cnt, FT); end
    tests++;
    if ({wr_bank, wr_en, clr_req} !== 3'b000) begin
      fails++; $display("FAIL basic_in_swap: wr_bank,wr_en,clr_req got %b expected 000",
                        {wr_bank, wr_en, clr_req});
    end
    @(negedge clk);
    tests++;
    if ({wr_bank, rd_bank, frame_valid, clr_req, swap} !== 5'b10110) begin
      fails++; $display("FAIL basic_after_swap: got %b expected 10110",
                        {wr_bank, rd_bank, frame_valid, clr_req, swap});
    end
    tests++;
    if (frame_cnt !== 16'd1) begin fails++; $display("FAIL basic_frame_cnt: got %0d expected 1", frame_cnt); end
    $display("[TB] test_basic_frame done");
  endtask

  task automatic test_wait_rd;
    bit ok;
    int cnt;
    apply_reset();
    enable  = 1'b1;
    rd_busy = 1'b1;
    do_clear(2, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL waitrd_clr_req: got timeout expected clr_req"); end
    // 8 accumulate cycles plus 5 more with the reader busy.
    cnt = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (wr_en === 1'b1 && swap === 1'b0) cnt++;
    end
    tests++;
    if (cnt != 13) begin fails++; $display("FAIL waitrd_wr_en_held: got %0d expected 13", cnt); end
    rd_busy = 1'b0;
    @(negedge clk);
    tests++;
    if ({swap, wr_en} !== 2'b10) begin
      fails++; $display("FAIL waitrd_swap: swap,wr_en got %b expected 10", {swap, wr_en});
    end
    @(negedge clk);
    tests++;
    if ({wr_bank, rd_bank, frame_valid} !== 3'b101 || frame_cnt !== 16'd1) begin
      fails++; $display("FAIL waitrd_after_swap: banks/valid got %b cnt %0d expected 101 cnt 1",
                        {wr_bank, rd_bank, frame_valid}, frame_cnt);
    end
    $display("[TB] test_wait_rd done");
  endtask

  task automatic test_discard;
    bit ok;
    int cnt;
    apply_reset();
    enable  = 1'b1;
    rd_busy = 1'b1;
    do_clear(2, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL discard_clr_req: got timeout expected clr_req"); end
    cnt = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge clk);
      if (wr_en === 1'b1 && swap === 1'b0) cnt++;
    end
    tests++;
    if (cnt != 2 * FT) begin fails++; $display("FAIL discard_wr_en_cycles: got %0d expected %0d", cnt, 2 * FT); end
    @(negedge clk);
    tests++;
    if ({clr_req, wr_en, wr_bank, rd_bank, frame_valid, swap} !== 6'b100100) begin
      fails++; $display("FAIL discard_state: got %b expected 100100",
                        {clr_req, wr_en, wr_bank, rd_bank, frame_valid, swap});
    end
    tests++;
    if (frame_cnt !== 16'd0) begin fails++; $display("FAIL discard_frame_cnt: got %0d expected 0", frame_cnt); end
`ifdef EVT_FRAME_DROP_CNT_EN
    tests++;
    if (drop_cnt !== 16'd1) begin fails++; $display("FAIL discard_drop_cnt: got %0d expected 1", drop_cnt); end
`endif
    rd_busy = 1'b0;
    $display("[TB] test_discard done");
  endtask

  task automatic test_disable_in_clear;
    bit ok;
    int cnt;
    apply_reset();
    enable = 1'b1;
    do_clear(1, ok);
    wait_swap(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL dis_swap_seen: got timeout expected swap_o"); end
    @(negedge clk);
    tests++;
    if ({clr_req, frame_valid} !== 2'b11) begin
      fails++; $display("FAIL dis_pre: clr_req,frame_valid got %b expected 11", {clr_req, frame_valid});
    end
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (clr_req === 1'b1) cnt++;
    end
    tests++;
    if (cnt != 3) begin fails++; $display("FAIL dis_clr_req_held: got %0d expected 3", cnt); end
    @(posedge clk);
    #1 clr_done = 1'b1;
    @(posedge clk);
    #1 clr_done = 1'b0;
    @(negedge clk);
    tests++;
    if ({clr_req, frame_valid, wr_en, wr_bank} !== 4'b0001 || frame_cnt !== 16'd1) begin
      fails++; $display("FAIL dis_idle: clr_req,valid,wr_en,wr_bank got %b cnt %0d expected 0001 cnt 1",
                        {clr_req, frame_valid, wr_en, wr_bank}, frame_cnt);
    end
    // clr_done outside CLEAR must not start anything.
    #1 clr_done = 1'b1;
    @(posedge clk);
    #1 clr_done = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({clr_req, wr_en, swap} !== 3'b000) begin
      fails++; $display("FAIL dis_stay_idle: got %b expected 000", {clr_req, wr_en, swap});
    end
    $display("[TB] test_disable_in_clear done");
  endtask

  task automatic test_async_reset;
    bit ok;
    apply_reset();
    enable = 1'b1;
    do_clear(1, ok);
    wait_swap(ok);
    do_clear(1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL arst_second_clear: got timeout expected clr_req"); end
    repeat (3) @(posedge clk);
    #3;
    tests++;
    if ({wr_en, wr_bank} !== 2'b11) begin
      fails++; $display("FAIL arst_pre: wr_en,wr_bank got %b expected 11", {wr_en, wr_bank});
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({clr_req, clr_bank, wr_en, wr_bank, rd_bank, frame_valid, swap} !== 7'b0000100
        || frame_cnt !== 16'd0) begin
      fails++; $display("FAIL arst_accum: flags %b cnt %0d expected 0000100 cnt 0",
                        {clr_req, clr_bank, wr_en, wr_bank, rd_bank, frame_valid, swap}, frame_cnt);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (clr_req === 1'b1) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL arst_reenter_clear: got timeout expected clr_req"); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (clr_req !== 1'b0) begin fails++; $display("FAIL arst_clear_drop: clr_req got %b expected 0", clr_req); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    enable = 1'b0;
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_wrap;
    bit ok;
    logic [CWW-1:0] exp_cnt;
    enable_w = 1'b1;
    exp_cnt  = '0;
    for (int f = 0; f < 16; f++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (clr_req_w === 1'b1) begin ok = 1'b1; break; end
      end
      if (ok) begin
        @(posedge clk);
        #1 clr_done_w = 1'b1;
        @(posedge clk);
        #1 clr_done_w = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (swap_w === 1'b1) begin ok = 1'b1; break; end
        end
      end
      @(negedge clk);
      exp_cnt = exp_cnt + 1'b1;
      tests++;
      if (!ok || frame_cnt_w !== exp_cnt) begin
        fails++; $display("FAIL wrap_frame_%0d: got cnt %0d ok %0b expected cnt %0d", f, frame_cnt_w, ok, exp_cnt);
      end
    end
    tests++;
    if (frame_cnt_w !== 4'd0 || wr_bank_w !== 1'b0) begin
      fails++; $display("FAIL wrap_final: cnt %0d wr_bank %b expected 0 0", frame_cnt_w, wr_bank_w);
    end
    enable_w = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (inv_err != 0) begin fails++; $display("FAIL bank_invariant: got %0d violations expected 0", inv_err); end
    $display("[TB] test_wrap done");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_wait_rd();
    test_discard();
    test_disable_in_clear();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
